mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external 32-bit memory bus between the IF stage (instruction fetch, read-only)
//  and the MEM stage (data load/store). Sequences each bus transaction, returns read data and a
//  one-cycle ack to the owning requester, and raises per-stage stall requests to ctrl until served.
// PARAMETERS
//  ADDR_W   32   bus/requester address width
//  DATA_W   32   bus/requester data width (`RegBus)
//  TIMEOUT  255  max wait cycles for bus_ack_i (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous reset, active-high (`RstEnable)
//  flush          in   1       pipeline flush; cancels delivery of a pending IF ack
//  if_req_i       in   1       IF read request; held until if_ack_o
//  if_addr_i      in   ADDR_W  IF fetch address
//  if_rdata_o     out  DATA_W  fetched instruction, valid while if_ack_o
//  if_ack_o       out  1       one-cycle IF completion pulse
//  mem_req_i      in   1       MEM request; held until mem_ack_o
//  mem_we_i       in   1       1 = store, 0 = load
//  mem_sel_i      in   4       byte lane enables
//  mem_addr_i     in   ADDR_W  MEM address
//  mem_wdata_i    in   DATA_W  store data
//  mem_rdata_o    out  DATA_W  load data, valid while mem_ack_o
//  mem_ack_o      out  1       one-cycle MEM completion pulse
//  bus_stb_o      out  1       bus request strobe
//  bus_we_o       out  1       bus write enable
//  bus_sel_o      out  4       bus byte lanes (IF: 4'b1111)
//  bus_addr_o     out  ADDR_W  bus address
//  bus_wdata_o    out  DATA_W  bus write data (IF: `ZeroWord)
//  bus_rdata_i    in   DATA_W  bus read data, sampled when bus_ack_i
//  bus_ack_i      in   1       bus completion; only meaningful while bus_stb_o
//  bus_err_o      out  1       transaction timed out (ARB_TIMEOUT_EN only)
//  stallreq_if_o  out  1       comb: if_req_i & ~if_ack_o
//  stallreq_mem_o out  1       comb: mem_req_i & ~mem_ack_o
// BEHAVIOUR
//  - Reset (sync): state IDLE; bus_stb_o/we/sel/addr/wdata = 0; both acks 0; rdata outs
//    `ZeroWord; bus_err_o 0; last_grant = IF (so MEM wins first tie). Reset mid-transaction
//    abandons bus cycle next edge; no ack is issued for it.
//  - FSM: IDLE -> MEM_XFER | IF_XFER -> DONE -> IDLE.
//  - IDLE: grant chosen from requests sampled this cycle. Only one pending -> grant it. Both ->
//    grant the one not in last_grant (round-robin). Grant registers bus_* next edge; bus_stb_o=1.
//  - XFER: bus_* held stable until bus_ack_i=1. On ack edge: bus_stb_o=0, rdata registered to
//    owner's rdata output, owner's ack=1, state DONE, last_grant=owner.
//  - DONE: exactly one cycle; ack high; no new grant; -> IDLE (requester drops req in DONE).
//  - Latency: req seen cycle N, bus_stb_o N+1, earliest bus_ack_i N+1, ack_o N+2, next bus_stb_o
//    N+4. Wait states on bus_ack_i add 1:1.
//  - Store: mem_rdata_o = `ZeroWord on ack. IF never drives bus_we_o.
//  - flush: if flush=1 in any cycle of an IF transaction (incl. DONE), if_ack_o is forced 0 for
//    that transaction; bus cycle still runs to completion. MEM transactions unaffected by flush.
//  - Requests raised while another transaction is active wait; stall outputs remain high.
//  - bus_ack_i while bus_stb_o=0 ignored.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: cycle counter cleared on entering XFER; if it reaches TIMEOUT with no
//    bus_ack_i, drop bus_stb_o, go DONE, ack owner with rdata `ZeroWord, bus_err_o=1 for the
//    DONE cycle. Counter cleared by rst.
//  ARB_TIMEOUT_EN undefined: no counter; XFER waits indefinitely; bus_err_o tied 0.
// TESTING
//  1 Load: mem_req=1,we=0,addr=0x100, bus acks N+1 with 0xDEADBEEF -> mem_ack N+2, rdata 0xDEADBEEF.
//  2 Tie: if_req & mem_req both at reset release -> MEM served first, then IF; bus_sel IF=4'hF.
//  3 Fairness: both held for 4 transactions -> grant order MEM,IF,MEM,IF; no back-to-back same.
//  4 Wait states: bus_ack delayed 5 cycles -> bus_addr/we/sel stable all 5, ack at N+7.
//  5 Flush: IF xfer, flush at N+1 -> bus cycle completes, if_ack_o never asserts.
//  6 Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): no bus_ack -> stb drops, ack+bus_err=1 together; rst mid-xfer -> all outputs 0 next edge.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the IF (fetch) and MEM (load/store) stages.
// Define ARB_TIMEOUT_EN to abort a transaction after TIMEOUT cycles without bus_ack_i.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  // instruction fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  // data load/store port
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  // external bus
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o,
  // stall requests to ctrl
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o
);

  typedef enum logic [1:0] {IDLE, MEM_XFER, IF_XFER, DONE} state_t;
  typedef enum logic {GNT_IF, GNT_MEM} grant_t;

  state_t state;
  grant_t last_grant;
  logic   if_ack_q;
  logic   if_flushed;
  logic   grant_mem;
  logic   grant_if;
  logic   in_xfer;
  logic   timed_out;
  logic   xfer_end;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mem_bus_arbiter: TIMEOUT must be at least 1");
  end

  // Round-robin on a tie: the stage that did not own the last transaction wins.
  assign grant_mem = mem_req_i && (!if_req_i || last_grant == GNT_IF);
  assign grant_if  = if_req_i && !grant_mem;

  assign in_xfer  = (state == MEM_XFER) || (state == IF_XFER);
  assign xfer_end = bus_ack_i || timed_out;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = in_xfer && !bus_ack_i && (wait_cnt == CNT_LAST);

  // Counter restarts every time the FSM passes through IDLE, i.e. on entry to XFER.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= timed_out;
      if (!in_xfer) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign timed_out = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  // NOTE: all state is assigned with <= so every branch sees pre-edge values;
  // read data registers are plain flops and take part in the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GNT_IF;
      bus_stb_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_o   <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
      if_flushed  <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_mem) begin
            state       <= MEM_XFER;
            bus_stb_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_sel_o   <= mem_sel_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
          end else if (grant_if) begin
            state       <= IF_XFER;
            bus_stb_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'hF;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
            if_flushed  <= flush;
          end
        end
        MEM_XFER: begin
          if (xfer_end) begin
            state       <= DONE;
            bus_stb_o   <= 1'b0;
            last_grant  <= GNT_MEM;
            mem_ack_o   <= 1'b1;
            mem_rdata_o <= (bus_we_o || timed_out) ? '0 : bus_rdata_i;
          end
        end
        IF_XFER: begin
          if (flush) begin
            if_flushed <= 1'b1;
          end
          if (xfer_end) begin
            state      <= DONE;
            bus_stb_o  <= 1'b0;
            last_grant <= GNT_IF;
            if_ack_q   <= !(if_flushed || flush);
            if_rdata_o <= timed_out ? '0 : bus_rdata_i;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A flush arriving during the DONE cycle must still suppress the registered ack.
  assign if_ack_o       = if_ack_q && !flush;
  assign stallreq_if_o  = if_req_i && !if_ack_o;
  assign stallreq_mem_o = mem_req_i && !mem_ack_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed, table-driven bench for mem_bus_arbiter plus hand-written
// sequences for wait states, flush, timeout/indefinite wait and reset mid-transaction.
module tb_mem_bus_arbiter;

  localparam logic [31:0] IF_A   = 32'h0000_0200;
  localparam logic [31:0] MEM_A  = 32'h0000_0100;
  localparam logic [31:0] MEM_WD = 32'hCAFE_F00D;
  localparam logic [3:0]  MEM_SEL = 4'h3;
  localparam int          N_VEC  = 20;

  typedef enum logic [1:0] {B_NONE, B_MLD, B_MST, B_IF} bus_t;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        if_req;
    logic        mem_req;
    logic        mem_we;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    bus_t        bus;
    logic        if_ack;
    logic        mem_ack;
    logic [31:0] if_rd;
    logic [31:0] mem_rd;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[N_VEC];

  mem_bus_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .if_req_i      (if_req_i),
    .if_addr_i     (if_addr_i),
    .if_rdata_o    (if_rdata_o),
    .if_ack_o      (if_ack_o),
    .mem_req_i     (mem_req_i),
    .mem_we_i      (mem_we_i),
    .mem_sel_i     (mem_sel_i),
    .mem_addr_i    (mem_addr_i),
    .mem_wdata_i   (mem_wdata_i),
    .mem_rdata_o   (mem_rdata_o),
    .mem_ack_o     (mem_ack_o),
    .bus_stb_o     (bus_stb_o),
    .bus_we_o      (bus_we_o),
    .bus_sel_o     (bus_sel_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_rdata_i   (bus_rdata_i),
    .bus_ack_i     (bus_ack_i),
    .bus_err_o     (bus_err_o),
    .stallreq_if_o (stallreq_if_o),
    .stallreq_mem_o(stallreq_mem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Expected bus drive for each kind of owner; attributes only matter while the strobe is up.
  task automatic check_bus(input string tag, input bus_t b);
    check1({tag, ".stb"}, bus_stb_o, b != B_NONE);
    if (b != B_NONE) begin
      check1 ({tag, ".we"},    bus_we_o,    b == B_MST);
      check32({tag, ".sel"},   {28'h0, bus_sel_o}, (b == B_IF) ? 32'hF : {28'h0, MEM_SEL});
      check32({tag, ".addr"},  bus_addr_o,  (b == B_IF) ? IF_A : MEM_A);
      check32({tag, ".wdata"}, bus_wdata_o, (b == B_IF) ? 32'h0 : MEM_WD);
    end
  endtask

  function automatic vec_t row(input logic r, input logic fl, input logic ifr, input logic memr,
                               input logic we, input logic back, input logic [31:0] brd,
                               input bus_t b, input logic ifa, input logic mema,
                               input logic [31:0] ifrd, input logic [31:0] memrd);
    vec_t v;
    v.rst = r;  v.flush = fl;  v.if_req = ifr;  v.mem_req = memr;  v.mem_we = we;
    v.bus_ack = back;  v.bus_rdata = brd;  v.bus = b;
    v.if_ack = ifa;  v.mem_ack = mema;  v.if_rd = ifrd;  v.mem_rd = memrd;
    return v;
  endfunction

  initial begin
    string tag;

    // Columns: rst flush if_req mem_req mem_we bus_ack bus_rdata | bus if_ack mem_ack if_rd mem_rd
    // Single load, a stray ack while idle, then reset, tie (MEM first) and alternating grants.
    vecs[0]  = row(0, 0, 0, 1, 0, 1, 32'hBAD0_BAD0, B_NONE, 0, 0, 32'h0, 32'h0);
    vecs[1]  = row(0, 0, 0, 1, 0, 1, 32'hDEAD_BEEF, B_MLD,  0, 0, 32'h0, 32'h0);
    vecs[2]  = row(0, 0, 0, 1, 0, 0, 32'h0,         B_NONE, 0, 1, 32'h0, 32'hDEAD_BEEF);
    vecs[3]  = row(1, 0, 0, 0, 0, 0, 32'h0,         B_NONE, 0, 0, 32'h0, 32'h0);
    vecs[4]  = row(0, 0, 1, 1, 0, 0, 32'h0,         B_NONE, 0, 0, 32'h0, 32'h0);
    vecs[5]  = row(0, 0, 1, 1, 0, 1, 32'h1111_1111, B_MLD,  0, 0, 32'h0, 32'h0);
    vecs[6]  = row(0, 0, 1, 1, 0, 0, 32'h0,         B_NONE, 0, 1, 32'h0, 32'h1111_1111);
    vecs[7]  = row(0, 0, 1, 1, 0, 0, 32'h0,         B_NONE, 0, 0, 32'h0, 32'h0);
    vecs[8]  = row(0, 0, 1, 1, 0, 1, 32'h2222_2222, B_IF,   0, 0, 32'h0, 32'h0);
    vecs[9]  = row(0, 0, 1, 1, 0, 0, 32'h0,         B_NONE, 1, 0, 32'h2222_2222, 32'h0);
    vecs[10] = row(0, 0, 1, 1, 1, 0, 32'h0,         B_NONE, 0, 0, 32'h0, 32'h0);
    vecs[11] = row(0, 0, 1, 1, 1, 1, 32'h3333_3333, B_MST,  0, 0, 32'h0, 32'h0);
    vecs[12] = row(0, 0, 1, 1, 0, 0, 32'h0,         B_NONE, 0, 1, 32'h0, 32'h0);
    vecs[13] = row(0, 0, 1, 1, 0, 0, 32'h0,         B_NONE, 0, 0, 32'h0, 32'h0);
    vecs[14] = row(0, 0, 1, 1, 0, 0, 32'h0,         B_IF,   0, 0, 32'h0, 32'h0);
    vecs[15] = row(0, 0, 1, 1, 0, 1, 32'h4444_4444, B_IF,   0, 0, 32'h0, 32'h0);
    vecs[16] = row(0, 0, 1, 1, 0, 0, 32'h0,         B_NONE, 1, 0, 32'h4444_4444, 32'h0);
    vecs[17] = row(0, 0, 0, 0, 0, 1, 32'h5555_5555, B_NONE, 0, 0, 32'h0, 32'h0);
    vecs[18] = row(0, 0, 0, 0, 0, 1, 32'h6666_6666, B_NONE, 0, 0, 32'h0, 32'h0);
    vecs[19] = row(0, 0, 0, 0, 0, 0, 32'h0,         B_NONE, 0, 0, 32'h0, 32'h0);

    rst = 1'b1;  flush = 1'b0;
    if_req_i = 1'b0;  if_addr_i = IF_A;
    mem_req_i = 1'b0;  mem_we_i = 1'b0;  mem_sel_i = MEM_SEL;
    mem_addr_i = MEM_A;  mem_wdata_i = MEM_WD;
    bus_rdata_i = 32'h0;  bus_ack_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check1 ("rst.stb",       bus_stb_o, 1'b0);
    check1 ("rst.we",        bus_we_o, 1'b0);
    check32("rst.sel",       {28'h0, bus_sel_o}, 32'h0);
    check32("rst.addr",      bus_addr_o, 32'h0);
    check32("rst.wdata",     bus_wdata_o, 32'h0);
    check1 ("rst.if_ack",    if_ack_o, 1'b0);
    check1 ("rst.mem_ack",   mem_ack_o, 1'b0);
    check32("rst.if_rdata",  if_rdata_o, 32'h0);
    check32("rst.mem_rdata", mem_rdata_o, 32'h0);
    check1 ("rst.err",       bus_err_o, 1'b0);

    // Table: one row per clock cycle, inputs driven at negedge and outputs sampled 1 later.
    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      flush       = vecs[i].flush;
      if_req_i    = vecs[i].if_req;
      mem_req_i   = vecs[i].mem_req;
      mem_we_i    = vecs[i].mem_we;
      bus_ack_i   = vecs[i].bus_ack;
      bus_rdata_i = vecs[i].bus_rdata;
      #1;
      tag = $sformatf("vec%0d", i);
      check_bus(tag, vecs[i].bus);
      check1({tag, ".if_ack"},  if_ack_o,  vecs[i].if_ack);
      check1({tag, ".mem_ack"}, mem_ack_o, vecs[i].mem_ack);
      if (vecs[i].if_ack)  check32({tag, ".if_rdata"},  if_rdata_o,  vecs[i].if_rd);
      if (vecs[i].mem_ack) check32({tag, ".mem_rdata"}, mem_rdata_o, vecs[i].mem_rd);
      check1({tag, ".stall_if"},  stallreq_if_o,  vecs[i].if_req && !vecs[i].if_ack);
      check1({tag, ".stall_mem"}, stallreq_mem_o, vecs[i].mem_req && !vecs[i].mem_ack);
      check1({tag, ".err"}, bus_err_o, 1'b0);
    end

    // Five wait states: attributes stay stable, ack lands at N+7.
    @(negedge clk);
    mem_addr_i = 32'h0000_0304;  mem_sel_i = 4'hC;  mem_we_i = 1'b0;  mem_req_i = 1'b1;
    bus_ack_i = 1'b0;  bus_rdata_i = 32'h5A5A_5A5A;
    #1;
    check1("ws.stall_n", stallreq_mem_o, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus_ack_i = (k == 6);
      #1;
      tag = $sformatf("ws.n%0d", k);
      check1 ({tag, ".stb"},  bus_stb_o, 1'b1);
      check32({tag, ".addr"}, bus_addr_o, 32'h0000_0304);
      check32({tag, ".sel"},  {28'h0, bus_sel_o}, 32'hC);
      check1 ({tag, ".we"},   bus_we_o, 1'b0);
      check1 ({tag, ".ack"},  mem_ack_o, 1'b0);
    end
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    check1 ("ws.n7.ack",   mem_ack_o, 1'b1);
    check32("ws.n7.rdata", mem_rdata_o, 32'h5A5A_5A5A);
    check1 ("ws.n7.stb",   bus_stb_o, 1'b0);
    @(negedge clk);
    mem_req_i = 1'b0;  mem_addr_i = MEM_A;  mem_sel_i = MEM_SEL;

    // Flush during the strobe: bus completes, IF ack suppressed.
    @(negedge clk);
    if_req_i = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    #1;
    check1("fl1.stb", bus_stb_o, 1'b1);
    @(negedge clk);
    flush = 1'b0;  bus_ack_i = 1'b1;  bus_rdata_i = 32'h7777_7777;
    #1;
    check1("fl1.stb_hold", bus_stb_o, 1'b1);
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    check1("fl1.stb_done", bus_stb_o, 1'b0);
    check1("fl1.if_ack",   if_ack_o, 1'b0);
    check1("fl1.stall",    stallreq_if_o, 1'b1);
    @(negedge clk);
    if_req_i = 1'b0;
    #1;
    check1("fl1.if_ack_after", if_ack_o, 1'b0);

    // Flush in the DONE cycle only.
    @(negedge clk);
    if_req_i = 1'b1;
    @(negedge clk);
    bus_ack_i = 1'b1;  bus_rdata_i = 32'h8888_8888;
    #1;
    check1("fl2.stb", bus_stb_o, 1'b1);
    @(negedge clk);
    bus_ack_i = 1'b0;  flush = 1'b1;
    #1;
    check1("fl2.if_ack", if_ack_o, 1'b0);
    check1("fl2.stall",  stallreq_if_o, 1'b1);
    @(negedge clk);
    if_req_i = 1'b0;  flush = 1'b0;
    #1;
    check1("fl2.if_ack_after", if_ack_o, 1'b0);

    // MEM transaction is unaffected by a flush held throughout.
    @(negedge clk);
    mem_req_i = 1'b1;  flush = 1'b1;
    @(negedge clk);
    bus_ack_i = 1'b1;  bus_rdata_i = 32'h9999_9999;
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    check1 ("flm.ack",   mem_ack_o, 1'b1);
    check32("flm.rdata", mem_rdata_o, 32'h9999_9999);
    @(negedge clk);
    mem_req_i = 1'b0;  flush = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // TIMEOUT = 8: strobe for 8 cycles, then ack + error together with zero data.
    @(negedge clk);
    mem_req_i = 1'b1;  bus_ack_i = 1'b0;  bus_rdata_i = 32'hFFFF_FFFF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      check1($sformatf("to.n%0d.stb", k), bus_stb_o, 1'b1);
      check1($sformatf("to.n%0d.ack", k), mem_ack_o, 1'b0);
    end
    @(negedge clk);
    #1;
    check1 ("to.stb",   bus_stb_o, 1'b0);
    check1 ("to.ack",   mem_ack_o, 1'b1);
    check1 ("to.err",   bus_err_o, 1'b1);
    check32("to.rdata", mem_rdata_o, 32'h0);
    @(negedge clk);
    mem_req_i = 1'b0;
    #1;
    check1("to.err_clr", bus_err_o, 1'b0);
`else
    // Without the timeout the transfer waits for as long as the bus takes.
    @(negedge clk);
    mem_req_i = 1'b1;  bus_ack_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      #1;
      check1($sformatf("nw.n%0d.stb", k), bus_stb_o, 1'b1);
      check1($sformatf("nw.n%0d.ack", k), mem_ack_o, 1'b0);
      check1($sformatf("nw.n%0d.err", k), bus_err_o, 1'b0);
    end
    @(negedge clk);
    bus_ack_i = 1'b1;  bus_rdata_i = 32'h1234_5678;
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    check1 ("nw.ack",   mem_ack_o, 1'b1);
    check32("nw.rdata", mem_rdata_o, 32'h1234_5678);
    @(negedge clk);
    mem_req_i = 1'b0;
`endif

    // Reset mid-transaction (with a coincident bus ack): cycle abandoned, no ack.
    @(negedge clk);
    mem_req_i = 1'b1;  mem_we_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;  bus_ack_i = 1'b1;  bus_rdata_i = 32'hABCD_0123;
    #1;
    check1("rx.stb_pre", bus_stb_o, 1'b1);
    @(negedge clk);
    rst = 1'b0;  mem_req_i = 1'b0;  mem_we_i = 1'b0;  bus_ack_i = 1'b0;
    #1;
    check1 ("rx.stb",       bus_stb_o, 1'b0);
    check1 ("rx.we",        bus_we_o, 1'b0);
    check32("rx.sel",       {28'h0, bus_sel_o}, 32'h0);
    check32("rx.addr",      bus_addr_o, 32'h0);
    check32("rx.wdata",     bus_wdata_o, 32'h0);
    check1 ("rx.mem_ack",   mem_ack_o, 1'b0);
    check32("rx.mem_rdata", mem_rdata_o, 32'h0);
    check32("rx.if_rdata",  if_rdata_o, 32'h0);
    @(negedge clk);
    #1;
    check1("rx.mem_ack_late", mem_ack_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
